// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative signed multiply / restoring divide on magnitudes with sign fix-up into HI/LO.
// Optional MULDIV_DIVZERO_FAST_EN adds the Div0 output and a short divide-by-zero path.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
`ifdef MULDIV_DIVZERO_FAST_EN
  ,
  output logic             Div0
`endif
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIX, S_DONE} state_t;
  state_t r_state;
  logic r_op, r_sq, r_sr;
  logic [WIDTH-1:0] r_a, r_b;
  logic [2*WIDTH:0] r_acc;
  logic [CW-1:0] r_cnt;
`ifdef MULDIV_DIVZERO_FAST_EN
  logic r_fz;
`endif
  logic [WIDTH-1:0] w_abs_a, w_abs_b, w_quo, w_rem;
  logic [WIDTH:0] w_mup, w_trial;
  logic [2*WIDTH:0] w_mstep, w_dstep;
  logic [2*WIDTH-1:0] w_prod;
  logic w_b0;
  assign w_abs_a = r_a[WIDTH-1] ? -r_a : r_a;
  assign w_abs_b = r_b[WIDTH-1] ? -r_b : r_b;
  assign w_b0 = ~|r_b;
  // Multiplier bits are consumed from bit 0 while the product fills in from the top, carry included.
  assign w_mup = r_acc[2*WIDTH:WIDTH] + (r_acc[0] ? {1'b0, r_b} : '0);
  assign w_mstep = {1'b0, w_mup, r_acc[WIDTH-1:1]};
  // Divide: shifted remainder minus divisor; a clear top bit means the trial subtraction fits.
  assign w_trial = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_b};
  assign w_dstep = w_trial[WIDTH] ? {r_acc[2*WIDTH-1:0], 1'b0} : {w_trial, r_acc[WIDTH-2:0], 1'b1};
  assign w_prod = r_sq ? -r_acc[2*WIDTH-1:0] : r_acc[2*WIDTH-1:0];
  assign w_quo = r_sq ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem = r_sr ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_op <= 1'b0;
      r_sq <= 1'b0;
      r_sr <= 1'b0;
      r_a <= '0;
      r_b <= '0;
      r_acc <= '0;
      r_cnt <= '0;
      Busy <= 1'b0;
      Done <= 1'b0;
      HI <= '0;
      LO <= '0;
`ifdef MULDIV_DIVZERO_FAST_EN
      r_fz <= 1'b0;
      Div0 <= 1'b0;
`endif
    end else begin
      Done <= r_state == S_DONE;
`ifdef MULDIV_DIVZERO_FAST_EN
      Div0 <= r_state == S_DONE && r_fz;
`endif
      case (r_state)
        S_IDLE: if (Start) begin
          r_op <= Op;
          r_a <= A;
          r_b <= B;
          Busy <= 1'b1;
          r_state <= S_PREP;
        end
        S_PREP: begin
          r_sq <= r_a[WIDTH-1] ^ r_b[WIDTH-1];
          r_sr <= r_a[WIDTH-1];
          r_b <= w_abs_b;
          r_acc <= {{(WIDTH+1){1'b0}}, w_abs_a};
          r_cnt <= CW'(WIDTH);
          r_state <= S_ITER;
`ifdef MULDIV_DIVZERO_FAST_EN
          r_fz <= r_op && w_b0;
          if (r_op && w_b0) begin
            HI <= r_a;
            LO <= '1;
            r_state <= S_DONE;
          end
`endif
        end
        S_ITER: begin
          r_acc <= r_op ? w_dstep : w_mstep;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) r_state <= S_FIX;
        end
        S_FIX: begin
          if (!r_op) {HI, LO} <= w_prod;
          else if (w_b0) begin
            HI <= r_a;
            LO <= '1;
          end else begin
            HI <= w_rem;
            LO <= w_quo;
          end
          r_state <= S_DONE;
        end
        S_DONE: begin
          Busy <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: randomized scoreboard bench for muldiv_sequencer against a plain-arithmetic signed model.
module tb_muldiv_sequencer;
  localparam int W = 32;
  logic Clock = 1'b0, Reset = 1'b1, Start = 1'b0, Op = 1'b0;
  logic [W-1:0] A = '0, B = '0;
  logic Busy, Done;
  logic [W-1:0] HI, LO;
`ifdef MULDIV_DIVZERO_FAST_EN
  logic Div0;
  localparam bit FZ = 1'b1;
`else
  localparam bit FZ = 1'b0;
`endif
  typedef struct {
    logic [31:0] hi, lo;
    int s, lat;
    logic d0;
  } exp_t;
  exp_t sb[$];
  int tests = 0, fails = 0, cyc = 0, busy_n = 0;
  muldiv_sequencer #(.WIDTH(W)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
    .Busy(Busy), .Done(Done), .HI(HI), .LO(LO)
`ifdef MULDIV_DIVZERO_FAST_EN
    , .Div0(Div0)
`endif
  );
  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc++;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  function automatic void model(input logic op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo);
    longint sx, sy;
    logic [63:0] p;
    sx = longint'($signed(a));
    sy = longint'($signed(b));
    if (!op) begin
      p = 64'(sx * sy);
      hi = p[63:32];
      lo = p[31:0];
    end else if (b == 0) begin
      hi = a;
      lo = '1;
    end else begin
      lo = 32'(sx / sy);
      hi = 32'(sx % sy);
    end
  endfunction
  task automatic issue(input logic op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    model(op, a, b, e.hi, e.lo);
    e.d0 = FZ && op && b == 0;
    e.lat = e.d0 ? 2 : W + 3;
    e.s = cyc + 1;
    sb.push_back(e);
    Op = op;
    A = a;
    B = b;
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    Op = 1'($urandom);
    A = $urandom;
    B = $urandom;
  endtask
  task automatic wait_done();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge Clock);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL timeout: %0d results still pending, expected 0", sb.size());
      sb.delete();
    end
  endtask
  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction
  always @(negedge Clock) begin
    exp_t e;
    if (Reset) busy_n = 0;
    else begin
      if (Busy) busy_n++;
`ifdef MULDIV_DIVZERO_FAST_EN
      if (!Done) chk("div0_quiet", 64'(Div0), 64'(0));
`endif
      if (Done) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: Done=1 expected 0 (HI=%h LO=%h)", HI, LO);
        end else begin
          e = sb.pop_front();
          chk("hi", 64'(HI), 64'(e.hi));
          chk("lo", 64'(LO), 64'(e.lo));
          chk("latency", 64'(cyc - e.s), 64'(e.lat));
          chk("busy_cycles", 64'(busy_n), 64'(e.lat));
          chk("busy_low_at_done", 64'(Busy), 64'(0));
`ifdef MULDIV_DIVZERO_FAST_EN
          chk("div0", 64'(Div0), 64'(e.d0));
`endif
        end
        busy_n = 0;
      end
    end
  end
  initial begin
    repeat (2) @(negedge Clock);
    chk("rst_busy", 64'(Busy), 64'(0));
    chk("rst_done", 64'(Done), 64'(0));
    chk("rst_hi", 64'(HI), 64'(0));
    chk("rst_lo", 64'(LO), 64'(0));
    Reset = 1'b0;
    @(negedge Clock);
    issue(1'b0, 32'd7, 32'hFFFFFFFD); wait_done();
    issue(1'b1, 32'hFFFFFFF9, 32'd2); wait_done();
    issue(1'b1, 32'd100, 32'd7); wait_done();
    issue(1'b1, 32'h80000000, 32'hFFFFFFFF); wait_done();
    issue(1'b0, 32'h80000000, 32'h80000000); wait_done();
    issue(1'b1, 32'h1234, 32'h0); wait_done();
    issue(1'b1, 32'd50, 32'hFFFFFFFA); wait_done();
    issue(1'b0, 32'h12345678, 32'h9ABCDEF1);
    repeat (4) @(negedge Clock);
    Start = 1'b1; Op = 1'b1; A = $urandom; B = $urandom;
    @(negedge Clock);
    Start = 1'b0;
    repeat (28) @(negedge Clock);
    Start = 1'b1; Op = 1'b0; A = $urandom; B = $urandom;
    @(negedge Clock);
    Start = 1'b0;
    wait_done();
    issue(1'b0, 32'hDEADBEEF, 32'h00C0FFEE);
    repeat (10) @(negedge Clock);
    #2 Reset = 1'b1;
    #1;
    chk("midrst_busy", 64'(Busy), 64'(0));
    chk("midrst_done", 64'(Done), 64'(0));
    chk("midrst_hi", 64'(HI), 64'(0));
    chk("midrst_lo", 64'(LO), 64'(0));
    sb.delete();
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    issue(1'b1, 32'hFFFFFC18, 32'd37); wait_done();
    for (int i = 0; i < 60; i++) begin
      issue(1'($urandom), pick(), pick());
      wait_done();
      repeat ($urandom_range(0, 2)) @(negedge Clock);
    end
    repeat (5) @(negedge Clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
